// File: rtl/uart_axi_lite.sv
// rtl/uart_axi_lite.sv - AXI4-Lite slave UART, 8N1, with independent RX and TX FIFOs.
module uart_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;

  // The extra pointer bit tells a full ring from an empty one.
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign dout  = mem[rptr[AW-1:0]];

  always_ff @(posedge CLK) begin
    if (push && !full) mem[wptr[AW-1:0]] <= din;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N || flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + 1'b1;
      if (pop && !empty) rptr <= rptr + 1'b1;
    end
  end
endmodule

module uart_axi_lite #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16,
  parameter int FIFO_AW      = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [3:0]  ARADDR,
  input  logic        ARVALID,
  output logic        ARREADY,
  output logic [31:0] RDATA,
  output logic [1:0]  RRESP,
  output logic        RVALID,
  input  logic        RREADY,
  input  logic [3:0]  AWADDR,
  input  logic        AWVALID,
  output logic        AWREADY,
  input  logic [31:0] WDATA,
  input  logic [3:0]  WSTRB,
  input  logic        WVALID,
  output logic        WREADY,
  output logic [1:0]  BRESP,
  output logic        BVALID,
  input  logic        BREADY,
  input  logic        RXD,
  output logic        TXD
);
  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic [7:0] tx_head, rx_head;
  logic       tx_empty, tx_full, rx_empty, rx_full;
  logic       tx_push, tx_pop, tx_flush;
  logic       rx_push, rx_pop, rx_flush;
  logic       overrun, frame_err, overrun_set, frame_set, stat_clr;
  logic [31:0] stat, rd_mux;

  assign RRESP = 2'b00;
  assign BRESP = 2'b00;

  logic unused_bits;
  assign unused_bits = ^{ARADDR[1:0], AWADDR[1:0], WDATA[31:8], WSTRB[3:1]};

  // ---------------- read channel ----------------
  rd_state_t rd_state, rd_state_n;

  always_ff @(posedge CLK) begin
    if (!RST_N) rd_state <= RD_IDLE;
    else        rd_state <= rd_state_n;
  end

  always_comb begin
    rd_state_n = rd_state;
    ARREADY    = 1'b0;
    case (rd_state)
      RD_IDLE: if (ARVALID) begin
        ARREADY    = 1'b1;
        rd_state_n = RD_DATA;
      end
      RD_DATA: if (RREADY) rd_state_n = RD_IDLE;
      default: rd_state_n = RD_IDLE;
    endcase
  end

  assign RVALID   = (rd_state == RD_DATA);
  assign rx_pop   = ARREADY && (ARADDR[3:2] == 2'd0);
  assign stat_clr = ARREADY && (ARADDR[3:2] == 2'd2);
  assign stat     = {25'd0, frame_err, overrun, 1'b0, tx_full, tx_empty, rx_full, !rx_empty};

  always_comb begin
    rd_mux = 32'd0;
    case (ARADDR[3:2])
      2'd0:    rd_mux = {24'd0, rx_empty ? 8'd0 : rx_head};
      2'd2:    rd_mux = stat;
      default: rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N)       RDATA <= 32'd0;
    else if (ARREADY) RDATA <= rd_mux;
  end

  // ---------------- write channel ----------------
  logic       aw_held, w_held, wstrb0_q;
  logic [1:0] awaddr_q;
  logic [7:0] wdata_q;
  logic       have_aw, have_w, do_write, wr_en;
  logic [1:0] wr_sel;
  logic [7:0] wr_data;

  assign AWREADY = AWVALID && !aw_held && !BVALID;
  assign WREADY  = WVALID && !w_held && !BVALID;
  assign have_aw = aw_held || AWREADY;
  assign have_w  = w_held || WREADY;
  // A beat accepted this cycle is used directly, so AW+W together reach BVALID in one cycle.
  assign do_write = have_aw && have_w;
  assign wr_sel   = aw_held ? awaddr_q : AWADDR[3:2];
  assign wr_data  = w_held ? wdata_q : WDATA[7:0];
  assign wr_en    = do_write && (w_held ? wstrb0_q : WSTRB[0]);
  assign tx_push  = wr_en && (wr_sel == 2'd1);
  assign tx_flush = wr_en && (wr_sel == 2'd3) && wr_data[0];
  assign rx_flush = wr_en && (wr_sel == 2'd3) && wr_data[1];

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      awaddr_q <= 2'd0;
      wdata_q  <= 8'd0;
      wstrb0_q <= 1'b0;
      BVALID   <= 1'b0;
    end else begin
      if (do_write) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        BVALID  <= 1'b1;
      end else begin
        if (AWREADY) begin
          aw_held  <= 1'b1;
          awaddr_q <= AWADDR[3:2];
        end
        if (WREADY) begin
          w_held   <= 1'b1;
          wdata_q  <= WDATA[7:0];
          wstrb0_q <= WSTRB[0];
        end
        if (BVALID && BREADY) BVALID <= 1'b0;
      end
    end
  end

  uart_fifo #(.W(8), .DEPTH(FIFO_DEPTH), .AW(FIFO_AW)) u_tx_fifo (
    .CLK(CLK), .RST_N(RST_N), .flush(tx_flush), .push(tx_push), .pop(tx_pop),
    .din(wr_data), .dout(tx_head), .empty(tx_empty), .full(tx_full)
  );

  // ---------------- TX shifter ----------------
  tx_state_t     tx_state, tx_state_n;
  logic [CW-1:0] tx_cnt, tx_cnt_n;
  logic [2:0]    tx_bit, tx_bit_n;
  logic [7:0]    tx_sh, tx_sh_n;
  logic          txd_n;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      tx_state <= T_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= 3'd0;
      tx_sh    <= 8'd0;
      TXD      <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_sh    <= tx_sh_n;
      TXD      <= txd_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit;
    tx_sh_n    = tx_sh;
    tx_pop     = 1'b0;
    case (tx_state)
      T_IDLE: if (!tx_empty) begin
        tx_pop     = 1'b1;
        tx_sh_n    = tx_head;
        tx_cnt_n   = '0;
        tx_state_n = T_START;
      end
      T_START: if (tx_cnt == BIT_LAST) begin
        tx_cnt_n   = '0;
        tx_bit_n   = 3'd0;
        tx_state_n = T_DATA;
      end else tx_cnt_n = tx_cnt + 1'b1;
      T_DATA: if (tx_cnt == BIT_LAST) begin
        tx_cnt_n = '0;
        tx_sh_n  = {1'b0, tx_sh[7:1]};
        if (tx_bit == 3'd7) tx_state_n = T_STOP;
        else                tx_bit_n   = tx_bit + 1'b1;
      end else tx_cnt_n = tx_cnt + 1'b1;
      T_STOP: if (tx_cnt == BIT_LAST) begin
        tx_cnt_n = '0;
        // Chain straight into the next start bit so queued frames leave no idle gap.
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_sh_n    = tx_head;
          tx_state_n = T_START;
        end else tx_state_n = T_IDLE;
      end else tx_cnt_n = tx_cnt + 1'b1;
      default: tx_state_n = T_IDLE;
    endcase
    case (tx_state_n)
      T_START: txd_n = 1'b0;
      T_DATA:  txd_n = tx_sh_n[0];
      default: txd_n = 1'b1;
    endcase
  end

  // ---------------- RX deserialiser ----------------
  logic          rx_s1, rx_s2, rx_prev;
  rx_state_t     rx_state, rx_state_n;
  logic [CW-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]    rx_bit, rx_bit_n;
  logic [7:0]    rx_sh, rx_sh_n;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= 3'd0;
      rx_sh    <= 8'd0;
    end else begin
      rx_s1    <= RXD;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_sh    <= rx_sh_n;
    end
  end

  always_comb begin
    rx_state_n  = rx_state;
    rx_cnt_n    = rx_cnt;
    rx_bit_n    = rx_bit;
    rx_sh_n     = rx_sh;
    rx_push     = 1'b0;
    overrun_set = 1'b0;
    frame_set   = 1'b0;
    case (rx_state)
      RX_IDLE: if (rx_prev && !rx_s2) begin
        rx_cnt_n   = '0;
        rx_state_n = RX_START;
      end
      RX_START: if (rx_cnt == HALF_LAST) begin
        rx_cnt_n   = '0;
        rx_bit_n   = 3'd0;
        rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
      end else rx_cnt_n = rx_cnt + 1'b1;
      RX_DATA: if (rx_cnt == BIT_LAST) begin
        rx_cnt_n = '0;
        rx_sh_n  = {rx_s2, rx_sh[7:1]};
        if (rx_bit == 3'd7) rx_state_n = RX_STOP;
        else                rx_bit_n   = rx_bit + 1'b1;
      end else rx_cnt_n = rx_cnt + 1'b1;
      RX_STOP: if (rx_cnt == BIT_LAST) begin
        rx_cnt_n   = '0;
        rx_state_n = RX_IDLE;
        if (!rx_s2)       frame_set   = 1'b1;
        else if (rx_full) overrun_set = 1'b1;
        else              rx_push     = 1'b1;
      end else rx_cnt_n = rx_cnt + 1'b1;
      default: rx_state_n = RX_IDLE;
    endcase
  end

  uart_fifo #(.W(8), .DEPTH(FIFO_DEPTH), .AW(FIFO_AW)) u_rx_fifo (
    .CLK(CLK), .RST_N(RST_N), .flush(rx_flush), .push(rx_push), .pop(rx_pop),
    .din(rx_sh), .dout(rx_head), .empty(rx_empty), .full(rx_full)
  );

  // Sticky error bits: a STAT read clears them unless a new error lands in the same cycle.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= overrun_set || (overrun && !stat_clr);
      frame_err <= frame_set || (frame_err && !stat_clr);
    end
  end
endmodule

// File: tb/tb_uart_axi_lite.sv
// tb/tb_uart_axi_lite.sv - directed self-checking bench for uart_axi_lite.
module tb_uart_axi_lite;
  localparam int CPB = 16;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [3:0]  ARADDR = 4'd0;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY = 1'b0;
  logic [3:0]  AWADDR = 4'd0;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic [31:0] WDATA = 32'd0;
  logic [3:0]  WSTRB = 4'd0;
  logic        WVALID = 1'b0;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY = 1'b0;
  logic        RXD = 1'b1;
  logic        TXD;

  int checks = 0;
  int errors = 0;
  logic [7:0] tx_q[$];
  logic       mon_en = 1'b0;
  logic [31:0] d;
  logic [9:0]  exp_bits;
  logic [7:0]  first_byte;
  int lat, n;

  uart_axi_lite #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(16), .FIFO_AW(4)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .RXD(RXD), .TXD(TXD)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Decodes every frame leaving TXD, sampling in the middle of each bit.
  always begin : tx_monitor
    logic [7:0] b;
    @(negedge CLK);
    if (mon_en && TXD === 1'b0) begin
      repeat (CPB / 2) @(negedge CLK);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge CLK);
        b[i] = TXD;
      end
      repeat (CPB) @(negedge CLK);
      tx_q.push_back(b);
    end
  end

  task automatic axi_read(input logic [3:0] a, output logic [31:0] rd);
    int k;
    @(negedge CLK);
    ARADDR = a; ARVALID = 1'b1; RREADY = 1'b0;
    #1;
    k = 0;
    while (!ARREADY && k < 20) begin @(negedge CLK); #1; k++; end
    check("ar_handshake", 32'(k < 20), 32'd1);
    @(negedge CLK);
    ARVALID = 1'b0;
    k = 0;
    while (!RVALID && k < 20) begin @(negedge CLK); k++; end
    check("r_valid", 32'(k < 20), 32'd1);
    rd = RDATA;
    RREADY = 1'b1;
    @(negedge CLK);
    RREADY = 1'b0;
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] wd, input logic [3:0] s, output int l);
    @(negedge CLK);
    AWADDR = a; AWVALID = 1'b1; WDATA = wd; WSTRB = s; WVALID = 1'b1; BREADY = 1'b0;
    #1;
    check("aw_w_ready", {30'd0, AWREADY, WREADY}, 32'h3);
    @(negedge CLK);
    AWVALID = 1'b0; WVALID = 1'b0;
    l = 1;
    while (!BVALID && l < 20) begin @(negedge CLK); l++; end
    check("b_valid", 32'(BVALID), 32'd1);
    BREADY = 1'b1;
    @(negedge CLK);
    BREADY = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    @(negedge CLK);
    RXD = 1'b0;
    repeat (CPB) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      RXD = b[i];
      repeat (CPB) @(negedge CLK);
    end
    RXD = stop;
    repeat (CPB) @(negedge CLK);
    RXD = 1'b1;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_txd", 32'(TXD), 32'd1);
    check("rst_arready", 32'(ARREADY), 32'd0);
    check("rst_rvalid", 32'(RVALID), 32'd0);
    check("rst_awready", 32'(AWREADY), 32'd0);
    check("rst_wready", 32'(WREADY), 32'd0);
    check("rst_bvalid", 32'(BVALID), 32'd0);
    check("rst_rdata", RDATA, 32'd0);
    RST_N = 1'b1;
    mon_en = 1'b1;

    axi_read(4'h8, d);
    check("stat_after_reset", d, 32'h04);
    check("txd_idle", 32'(TXD), 32'd1);
    axi_read(4'h0, d);
    check("rx_empty_read", d, 32'h00);
    check("rresp", 32'(RRESP), 32'd0);

    // Transmit 0x41 and check the exact line waveform
    axi_write(4'h4, 32'h41, 4'b0001, lat);
    check("bvalid_latency", 32'(lat <= 2), 32'd1);
    check("bresp", 32'(BRESP), 32'd0);
    n = 0;
    while (TXD !== 1'b0 && n < 50) begin @(negedge CLK); n++; end
    check("tx_start_seen", 32'(n < 50), 32'd1);
    exp_bits = 10'b10_1000_0010;
    repeat (CPB / 2) @(negedge CLK);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("tx_0x41_bit%0d", i), 32'(TXD), 32'(exp_bits[i]));
      if (i < 9) repeat (CPB) @(negedge CLK);
    end

    // Receive one byte
    send_rx(8'h5A, 1'b1);
    axi_read(4'h8, d);
    check("stat_rx_valid", d, 32'h05);
    axi_read(4'h0, d);
    check("rx_byte_5a", d, 32'h5A);
    axi_read(4'h8, d);
    check("stat_after_pop", d, 32'h04);

    // A write with WSTRB[0]=0 must not start a frame
    axi_write(4'h4, 32'h66, 4'b1110, lat);
    n = 0;
    for (int i = 0; i < 3 * CPB; i++) begin
      @(negedge CLK);
      if (TXD !== 1'b1) n++;
    end
    check("wstrb0_no_tx", 32'(n), 32'd0);

    // Overrun: 17 frames into a 16-deep FIFO
    for (int i = 0; i < 17; i++) send_rx(8'(8'h10 + i), 1'b1);
    axi_read(4'h8, d);
    check("stat_overrun", d, 32'h27);
    axi_read(4'h8, d);
    check("stat_overrun_cleared", d, 32'h07);
    for (int i = 0; i < 16; i++) begin
      axi_read(4'h0, d);
      check($sformatf("rx_order_%0d", i), d, 32'(8'h10 + i));
    end
    axi_read(4'h8, d);
    check("stat_drained", d, 32'h04);

    // Stop bit low -> frame error, nothing pushed
    send_rx(8'h33, 1'b0);
    axi_read(4'h8, d);
    check("stat_frame_err", d, 32'h44);
    axi_read(4'h8, d);
    check("stat_frame_err_cleared", d, 32'h04);

    // Short glitch -> false start
    @(negedge CLK);
    RXD = 1'b0;
    repeat (CPB / 4) @(negedge CLK);
    RXD = 1'b1;
    repeat (3 * CPB) @(negedge CLK);
    axi_read(4'h8, d);
    check("glitch_no_frame", d, 32'h04);

    // RREADY stall with ARVALID still asserted: data held, no second pop
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    @(negedge CLK);
    ARADDR = 4'h0; ARVALID = 1'b1; RREADY = 1'b0;
    #1;
    check("stall_arready", 32'(ARREADY), 32'd1);
    @(negedge CLK);
    for (int i = 0; i < 10; i++) begin
      check("stall_rdata", RDATA, 32'h11);
      check("stall_rvalid", 32'(RVALID), 32'd1);
      check("stall_arready_low", 32'(ARREADY), 32'd0);
      @(negedge CLK);
    end
    ARVALID = 1'b0; RREADY = 1'b1;
    @(negedge CLK);
    RREADY = 1'b0;
    axi_read(4'h0, d);
    check("after_stall_next", d, 32'h22);
    axi_read(4'h8, d);
    check("after_stall_stat", d, 32'h04);

    // TX overflow: 18 writes, 17 frames leave
    tx_q.delete();
    for (int i = 0; i < 18; i++) axi_write(4'h4, 32'(8'h80 + i), 4'b0001, lat);
    axi_read(4'h8, d);
    check("stat_tx_full", d, 32'h08);
    n = 0;
    while (tx_q.size() < 17 && n < 4000) begin @(negedge CLK); n++; end
    check("tx_frames_timeout", 32'(n < 4000), 32'd1);
    repeat (30 * CPB) @(negedge CLK);
    check("tx_frame_count", 32'(tx_q.size()), 32'd17);
    for (int i = 0; i < 17; i++) begin
      first_byte = (i < tx_q.size()) ? tx_q[i] : 8'h00;
      check($sformatf("tx_order_%0d", i), 32'(first_byte), 32'(8'h80 + i));
    end

    // CTRL flushes
    send_rx(8'h77, 1'b1);
    axi_read(4'h8, d);
    check("stat_before_rx_flush", d, 32'h05);
    axi_write(4'hC, 32'h2, 4'b0001, lat);
    axi_read(4'h8, d);
    check("stat_after_rx_flush", d, 32'h04);
    tx_q.delete();
    axi_write(4'h4, 32'hA1, 4'b0001, lat);
    axi_write(4'h4, 32'hA2, 4'b0001, lat);
    axi_write(4'h4, 32'hA3, 4'b0001, lat);
    axi_write(4'hC, 32'h1, 4'b0001, lat);
    repeat (14 * CPB) @(negedge CLK);
    check("tx_flush_count", 32'(tx_q.size()), 32'd1);
    first_byte = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
    check("tx_flush_survivor", 32'(first_byte), 32'hA1);

    // Reset in the middle of an all-zero frame: TXD high on the next cycle
    axi_write(4'h4, 32'h00, 4'b0001, lat);
    n = 0;
    while (TXD !== 1'b0 && n < 50) begin @(negedge CLK); n++; end
    check("rst_mid_start_seen", 32'(n < 50), 32'd1);
    repeat (3 * CPB) @(negedge CLK);
    check("rst_mid_txd_low", 32'(TXD), 32'd0);
    mon_en = 1'b0;
    RST_N = 1'b0;
    @(negedge CLK);
    check("rst_mid_txd_high", 32'(TXD), 32'd1);
    RST_N = 1'b1;
    axi_read(4'h8, d);
    check("stat_after_mid_reset", d, 32'h04);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
